// File: rtl/dino_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dino_pkg : shared geometry, palette and state encoding for scene_render     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package dino_pkg;

    localparam int H_VIS      = 640;
    localparam int V_VIS      = 480;
    localparam int GROUND_ROW = 400;
    localparam int DINO_X     = 64;
    localparam int DINO_SIZE  = 32;

    localparam logic [11:0] COL_BLANK     = 12'h000;
    localparam logic [11:0] COL_BG        = 12'hFFF;
    localparam logic [11:0] COL_GROUND    = 12'h555;
    localparam logic [11:0] COL_DINO      = 12'h333;
    localparam logic [11:0] COL_DINO_OVER = 12'hF00;

    localparam int STATE_W = 1;
    localparam logic [STATE_W-1:0] ST_PLAY = 1'b0;
    localparam logic [STATE_W-1:0] ST_OVER = 1'b1;

endpackage
`default_nettype wire

// File: rtl/scene_render_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | scene_render_if : pixel-address / game-state bus between VGA side and       |
// | the scene renderer.  Rev 1.0                                                |
// +----------------------------------------------------------------------------+
interface scene_render_if;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic [5:0]  dinosaur_height;
    logic [5:0]  ground_position;
    logic        game_status;
    logic [11:0] vga_data;
    logic        frame_start;

    modport master (
        output row_addr, col_addr, dinosaur_height, ground_position, game_status,
        input  vga_data, frame_start
    );

    modport slave (
        input  row_addr, col_addr, dinosaur_height, ground_position, game_status,
        output vga_data, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/frame_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_sync : detects the row_addr wrap to 0 and emits a registered pulse    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module frame_sync (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [8:0] row_addr,
    output logic            start_det,
    output logic            frame_start
);

    logic [8:0] prev_row;

    // prev_row resets to 0, so a reset while row_addr is 0 cannot fake a start
    assign start_det = (row_addr == 9'd0) && (prev_row != 9'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_row    <= 9'd0;
            frame_start <= 1'b0;
        end else begin
            prev_row    <= row_addr;
            frame_start <= start_det;
        end
    end

endmodule
`default_nettype wire

// File: rtl/scene_render.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | scene_render : two-stage pixel renderer for the dinosaur runner scene       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module scene_render #(
    parameter int H_VIS      = dino_pkg::H_VIS,
    parameter int V_VIS      = dino_pkg::V_VIS,
    parameter int GROUND_ROW = dino_pkg::GROUND_ROW,
    parameter int DINO_X     = dino_pkg::DINO_X
) (
    input  wire logic     clk,
    input  wire logic     rst,
    scene_render_if.slave bus
);
    import dino_pkg::*;

    localparam logic [9:0] H_LIM    = 10'(H_VIS);
    localparam logic [9:0] V_LIM    = 10'(V_VIS);
    localparam logic [9:0] GND      = 10'(GROUND_ROW);
    localparam logic [9:0] DX_LO    = 10'(DINO_X);
    localparam logic [9:0] DX_HI    = 10'(DINO_X + DINO_SIZE - 1);
    localparam logic [9:0] DSIZE    = 10'(DINO_SIZE);

    logic                 start_det;
    logic [5:0]           height_snap;
    logic [5:0]           gpos_snap;
    logic [STATE_W-1:0]   state;
    logic [4:0]           blink_cnt;
    logic [8:0]           row_q;
    logic [9:0]           col_q;
    logic [9:0]           row_w;
    logic [9:0]           dino_top;
    logic [9:0]           dino_bot;
    logic [5:0]           gsum;
    logic                 blank;
    logic                 dino_hit;
    logic                 ground_hit;
    logic [11:0]          dino_col;
    logic [11:0]          pixel;

    frame_sync u_frame_sync (
        .clk         (clk),
        .rst         (rst),
        .row_addr    (bus.row_addr),
        .start_det   (start_det),
        .frame_start (bus.frame_start)
    );

    // Frame-level state: everything here changes only on a detected frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            height_snap <= 6'd0;
            gpos_snap   <= 6'd0;
            state       <= ST_PLAY;
            blink_cnt   <= 5'd0;
        end else if (start_det) begin
            height_snap <= bus.dinosaur_height;
            case (state)
                ST_PLAY: begin
                    gpos_snap <= bus.ground_position;
                    if (bus.game_status) begin
                        state     <= ST_OVER;
                        blink_cnt <= 5'd0;
                    end
                end
                ST_OVER: begin
                    if (!bus.game_status) begin
                        state     <= ST_PLAY;
                        gpos_snap <= bus.ground_position;
                    end else begin
                        blink_cnt <= blink_cnt + 5'd1;
                    end
                end
                default: state <= ST_PLAY;
            endcase
        end
    end

    always_comb begin
        row_w      = {1'b0, row_q};
        dino_top   = GND - DSIZE - {4'd0, height_snap};
        dino_bot   = GND - 10'd1 - {4'd0, height_snap};
        gsum       = col_q[5:0] + gpos_snap;
        blank      = (row_w >= V_LIM) || (col_q >= H_LIM);
        dino_hit   = (col_q >= DX_LO) && (col_q <= DX_HI) &&
                     (row_w >= dino_top) && (row_w <= dino_bot);
        ground_hit = (row_w >= GND) && (row_w <= GND + 10'd3) && !gsum[5];
        dino_col   = ((state == ST_OVER) && !blink_cnt[4]) ? COL_DINO_OVER : COL_DINO;
        pixel      = COL_BG;
        if (blank)           pixel = COL_BLANK;
        else if (dino_hit)   pixel = dino_col;
        else if (ground_hit) pixel = COL_GROUND;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q        <= 9'd0;
            col_q        <= 10'd0;
            bus.vga_data <= COL_BLANK;
        end else begin
            row_q        <= bus.row_addr;
            col_q        <= bus.col_addr;
            bus.vga_data <= pixel;
        end
    end

endmodule
`default_nettype wire
